// File: rtl/wait_state_memory_if.sv
// Memory request/response bundle between the multicycle core (master) and the wait-state memory (slave).
interface wait_state_memory_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mr;
    logic        mw;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output address, write_data, mr, mw,
        input  read_data, ready
    );

    modport slave (
        input  address, write_data, mr, mw,
        output read_data, ready
    );
endinterface

// File: rtl/wait_state_memory.sv
// Word-organised memory with programmable access latency and a one-cycle ready pulse.
// A request is latched on acceptance, completed LATENCY edges later, then held off until mr/mw drop.
module wait_state_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3,
    parameter string       INIT_FILE   = ""
) (
    input  logic               clk,
    input  logic               rst,
    wait_state_memory_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           wr_q, wr_d;
    logic           ready_q, ready_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           mem_we;
    logic           req;

    logic [31:0]    mem [DEPTH_WORDS];

    // Byte-offset and wrap-around address bits are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{bus.address[31:AW+2], bus.address[1:0]};

    assign req = bus.mr | bus.mw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req)            state_d = S_BUSY;
            S_BUSY:    if (cnt_q == '0)    state_d = S_RELEASE;
            S_RELEASE: if (!req)           state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values; a simultaneous mr/mw is a write.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = bus.address[AW+1:2];
                    wdata_d = bus.write_data;
                    wr_d    = bus.mw;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    ready_d = 1'b1;
                    if (wr_q) mem_we  = 1'b1;
                    else      rdata_d = mem[addr_q];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    assign bus.ready     = ready_q;
    assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Self-checking bench: directed vectors, reset corner cases and randomized traffic on LATENCY=3 and LATENCY=1 instances.
module tb_wait_state_memory;

    logic clk;
    logic rst3;
    logic rst1;

    wait_state_memory_if bus3 ();
    wait_state_memory_if bus1 ();

    wait_state_memory #(.DEPTH_WORDS(1024), .LATENCY(3), .INIT_FILE("")) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3.slave)
    );

    wait_state_memory #(.DEPTH_WORDS(1024), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: word arrays per instance plus the last completed read value.
    logic [31:0] mem_m   [2][1024];
    bit          known_m [2][1024];
    logic [31:0] last_m  [2];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int which, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus3.mr = rd; bus3.mw = wr; bus3.address = a; bus3.write_data = d;
        end else begin
            bus1.mr = rd; bus1.mw = wr; bus1.address = a; bus1.write_data = d;
        end
    endtask

    function automatic logic get_ready(input int which);
        return (which == 0) ? bus3.ready : bus1.ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int which);
        return (which == 0) ? bus3.read_data : bus1.read_data;
    endfunction

    // Called just after a falling edge with the DUT idle; returns just after a falling edge, ready for the next request.
    task automatic xact(input int which, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, input logic [31:0] exp_rd, input string name);
        int lat;
        int n;
        bit seen;
        lat  = (which == 0) ? 3 : 1;
        n    = 0;
        seen = 1'b0;
        drive(which, rd, wr, a, d);
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (scramble && n == 1) drive(which, rd, wr, $urandom, $urandom);
            if (get_ready(which) === 1'b1) seen = 1'b1;
        end
        chk({name, " latency"}, 32'(n - 1), 32'(lat));
        chk({name, " read_data"}, get_rdata(which), exp_rd);
        drive(which, 1'b0, 1'b0, $urandom, $urandom);
        @(negedge clk);
        chk({name, " ready pulse width"}, 32'(get_ready(which)), 32'd0);
    endtask

    function automatic logic [31:0] model_exp(input int which, input bit wr, input logic [31:0] a);
        return wr ? last_m[which] : mem_m[which][a[11:2]];
    endfunction

    function automatic void model_upd(input int which, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (wr) begin
            mem_m[which][a[11:2]]   = d;
            known_m[which][a[11:2]] = 1'b1;
        end else begin
            last_m[which] = mem_m[which][a[11:2]];
        end
    endfunction

    task automatic model_xact(input int which, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input bit scramble, input string name);
        xact(which, rd, wr, a, d, scramble, model_exp(which, wr, a), name);
        model_upd(which, wr, a, d);
    endtask

    initial begin
        int pulses;
        logic [31:0] a;
        int idx;
        bit wr;
        bit rd;

        tbl[0] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0010, data: 32'hDEADBEEF, exp: 32'h0000_0000};
        tbl[1] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0010, data: 32'h0000_0000, exp: 32'hDEADBEEF};
        tbl[2] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0013, data: 32'h12345678, exp: 32'hDEADBEEF};
        tbl[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1010, data: 32'h0000_0000, exp: 32'h12345678};
        tbl[4] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_0010, data: 32'hA5A5A5A5, exp: 32'h12345678};
        tbl[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_4010, data: 32'h0000_0000, exp: 32'hA5A5A5A5};

        for (int w = 0; w < 2; w++) begin
            last_m[w] = '0;
            for (int i = 0; i < 1024; i++) begin
                mem_m[w][i]   = '0;
                known_m[w][i] = 1'b0;
            end
        end

        // Reset held with a pending read request: no response may appear.
        rst3 = 1'b1;
        rst1 = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus3.ready === 1'b1) pulses++;
        end
        chk("reset ready", 32'(bus3.ready), 32'd0);
        chk("reset read_data", bus3.read_data, 32'd0);
        chk("reset ready l1", 32'(bus1.ready), 32'd0);
        chk("reset no pulse", 32'(pulses), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst3 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            xact(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0, tbl[i].exp, $sformatf("vec%0d", i));
            model_upd(0, tbl[i].wr, tbl[i].addr, tbl[i].data);
        end

        // Held read: one response over ten cycles.
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus3.ready === 1'b1) begin
                pulses++;
                chk("held read data", bus3.read_data, mem_m[0][4]);
            end
        end
        chk("held read pulse count", 32'(pulses), 32'd1);
        model_upd(0, 1'b0, 32'h0000_0010, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Address/data changed during BUSY are ignored.
        model_xact(0, 1'b0, 1'b1, 32'h0000_0014, 32'hCAFE0005, 1'b1, "scrambled write");
        model_xact(0, 1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b1, "scrambled read");

        // Reset one cycle before a write completes: write discarded, outputs clear at once.
        drive(0, 1'b0, 1'b1, 32'h0000_0014, 32'h11111111);
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        chk("mid-busy reset ready", 32'(bus3.ready), 32'd0);
        chk("mid-busy reset read_data", bus3.read_data, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst3 = 1'b0;
        last_m[0] = '0;
        xact(0, 1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'hCAFE0005, "discarded write");
        model_upd(0, 1'b0, 32'h0000_0014, 32'h0);

        // LATENCY=1: write, then back-to-back reads at the earliest acceptance.
        model_xact(1, 1'b0, 1'b1, 32'h0000_0008, 32'h0BADF00D, 1'b0, "l1 write");
        model_xact(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, "l1 read a");
        model_xact(1, 1'b1, 1'b0, 32'h0000_1009, 32'h0, 1'b0, "l1 read b");

        // Randomized traffic against the model.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 40; i++) begin
                idx = int'($urandom_range(0, 15));
                a   = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | ($urandom & 32'h3);
                wr  = ($urandom_range(0, 1) == 1) || !known_m[w][idx];
                rd  = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
                model_xact(w, rd, wr, a, $urandom, 1'($urandom_range(0, 1)), $sformatf("rand%0d_%0d", w, i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
